// File: rtl/rr_pkt_arbiter_pkg.sv
// Shared types and helpers for the round-robin packet arbiter.
package rr_pkt_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  // Next channel index with an explicit wrap, so non-power-of-two counts work.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pkt_arbiter_mux.sv
// One-hot AND-OR data selector: unselected inputs are masked to zero.
module rr_pkt_arbiter_mux #(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic [N-1:0]        sel,
  input  logic [N-1:0][W-1:0] din,
  output logic [W-1:0]        dout
);

  always_comb begin
    dout = '0;
    for (int k = 0; k < N; k++) begin
      dout = dout | (din[k] & {W{sel[k]}});
    end
  end

endmodule

// File: rtl/rr_pkt_arbiter.sv
// Round-robin arbiter that merges N beat streams into one registered output,
// holding the grant on a channel until its packet's last beat is accepted.
module rr_pkt_arbiter
  import rr_pkt_arbiter_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        i_in_vld,
  input  logic [N-1:0][W-1:0] i_in_w,
  input  logic [N-1:0]        i_in_last,
  output logic [N-1:0]        o_in_rdy,
  output logic                o_out_vld,
  output logic [W-1:0]        o_out_w,
  output logic                o_out_last,
  input  logic                i_out_rdy
);

  localparam int IW = $clog2(N);

  arb_state_e    state, state_nxt;
  logic [IW-1:0] ptr, ptr_nxt;
  logic [IW-1:0] lk, lk_nxt;
  logic [IW-1:0] gidx;
  logic          have_gnt;
  logic [N-1:0]  gnt_oh;
  logic [N-1:0]  rdy;
  logic          ld;
  logic          accept;
  logic          sel_last;
  logic [W-1:0]  sel_w;
  logic          vld_p1;
  logic [W-1:0]  w_p1;
  logic          last_p1;

  assign ld = !vld_p1 || i_out_rdy;

  // A locked channel keeps the grant even while its valid is low.
  always_comb begin : grant_select
    int cand;
    cand     = int'(ptr);
    gidx     = lk;
    have_gnt = (state == LOCK);
    if (state == IDLE) begin
      for (int i = 0; i < N; i++) begin
        if (!have_gnt && i_in_vld[IW'(cand)]) begin
          have_gnt = 1'b1;
          gidx     = IW'(cand);
        end
        cand = wrap_inc(cand, N);
      end
    end
  end

  always_comb begin
    gnt_oh = '0;
    if (have_gnt) gnt_oh[gidx] = 1'b1;
  end

  assign rdy      = rst ? '0 : (gnt_oh & {N{ld}});
  assign accept   = |(rdy & i_in_vld);
  assign sel_last = |(gnt_oh & i_in_last);

  rr_pkt_arbiter_mux #(
    .N (N),
    .W (W)
  ) u_mux (
    .sel  (gnt_oh),
    .din  (i_in_w),
    .dout (sel_w)
  );

  always_comb begin : next_state
    state_nxt = state;
    ptr_nxt   = ptr;
    lk_nxt    = lk;
    if (accept) begin
      if (sel_last) begin
        state_nxt = IDLE;
        ptr_nxt   = IW'(wrap_inc(int'(gidx), N));
      end else begin
        state_nxt = LOCK;
        lk_nxt    = gidx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      lk    <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      lk    <= lk_nxt;
    end
  end

  // Stage p1: output register, reloaded only when empty or being drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      w_p1    <= '0;
      last_p1 <= 1'b0;
    end else if (ld) begin
      vld_p1 <= accept;
      if (accept) begin
        w_p1    <= sel_w;
        last_p1 <= sel_last;
      end
    end
  end

  assign o_in_rdy   = rdy;
  assign o_out_vld  = vld_p1;
  assign o_out_w    = w_p1;
  assign o_out_last = last_p1;

endmodule

// File: tb/tb_rr_pkt_arbiter.sv
// Self-checking bench for rr_pkt_arbiter (N=4, W=8): vector table plus
// queued per-channel packet sources checked against an output scoreboard.
module tb_rr_pkt_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [N-1:0]        i_in_vld;
  logic [N-1:0][W-1:0] i_in_w;
  logic [N-1:0]        i_in_last;
  logic [N-1:0]        o_in_rdy;
  logic                o_out_vld;
  logic [W-1:0]        o_out_w;
  logic                o_out_last;
  logic                i_out_rdy;

  rr_pkt_arbiter #(.N(N), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_in_vld   (i_in_vld),
    .i_in_w     (i_in_w),
    .i_in_last  (i_in_last),
    .o_in_rdy   (o_in_rdy),
    .o_out_vld  (o_out_vld),
    .o_out_w    (o_out_w),
    .o_out_last (o_out_last),
    .i_out_rdy  (i_out_rdy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] w;
    logic         last;
  } beat_t;

  typedef struct packed {
    logic [3:0]   gap;
    logic         last;
    logic [W-1:0] w;
  } src_t;

  typedef struct packed {
    logic [N-1:0] vld;
    logic [N-1:0] last;
    logic [N-1:0] exp_rdy;
  } vec_t;

  beat_t exp_q[$];
  src_t  src_q[N][$];
  int    tests = 0;
  int    fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Output scoreboard and per-cycle handshake rules.
  int           inprog = -1;
  logic         stall_prev = 1'b0;
  logic         rst_prev = 1'b1;
  logic [W-1:0] w_prev;
  logic         last_prev;

  always @(negedge clk) begin : mon
    logic [N-1:0] acc;
    logic [N-1:0] mask;
    beat_t        b;
    if (o_out_vld && i_out_rdy) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_beat: got 0x%0h, expected none", o_out_w);
      end else begin
        b = exp_q.pop_front();
        check("out_w", 32'(o_out_w), 32'(b.w));
        check("out_last", 32'(o_out_last), 32'(b.last));
      end
    end
    if (stall_prev && !rst_prev) begin
      check("stall_vld", 32'(o_out_vld), 32'd1);
      check("stall_w", 32'(o_out_w), 32'(w_prev));
      check("stall_last", 32'(o_out_last), 32'(last_prev));
    end
    if (o_out_vld && !i_out_rdy) check("stall_rdy_zero", 32'(o_in_rdy), 32'd0);
    check("rdy_onehot", 32'($countones(o_in_rdy) <= 1), 32'd1);
    if (rst) begin
      check("rst_rdy_zero", 32'(o_in_rdy), 32'd0);
      inprog = -1;
    end else begin
      if (inprog >= 0) begin
        mask = '0;
        mask[inprog] = 1'b1;
        check("lock_exclusive", 32'(o_in_rdy & ~mask), 32'd0);
      end
      acc = i_in_vld & o_in_rdy;
      for (int k = 0; k < N; k++) begin
        if (acc[k]) inprog = i_in_last[k] ? -1 : k;
      end
    end
    stall_prev = o_out_vld && !i_out_rdy;
    rst_prev   = rst;
    w_prev     = o_out_w;
    last_prev  = o_out_last;
  end

  // Calls are made in the order beats must leave the arbiter.
  task automatic src(input int ch, input logic [W-1:0] w, input logic last, input int gap);
    src_q[ch].push_back('{gap: 4'(gap), last: last, w: w});
    exp_q.push_back('{w: w, last: last});
  endtask

  function automatic bit busy();
    bit b;
    b = (exp_q.size() != 0);
    for (int k = 0; k < N; k++) if (src_q[k].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic run_src(input string name, input int stall_at, input int stall_len,
                         input int exp_cycles);
    int           cyc;
    logic [N-1:0] acc;
    src_t         h;
    cyc = 0;
    while (busy() && cyc < 200) begin
      i_out_rdy = !(cyc >= stall_at && cyc < stall_at + stall_len);
      for (int k = 0; k < N; k++) begin
        if (src_q[k].size() > 0 && src_q[k][0].gap == 0) begin
          i_in_vld[k]  = 1'b1;
          i_in_w[k]    = src_q[k][0].w;
          i_in_last[k] = src_q[k][0].last;
        end else begin
          i_in_vld[k]  = 1'b0;
          i_in_w[k]    = '0;
          i_in_last[k] = 1'b0;
        end
      end
      @(negedge clk);
      acc = i_in_vld & o_in_rdy;
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
        if (acc[k]) begin
          h = src_q[k].pop_front();
        end else if (src_q[k].size() > 0 && src_q[k][0].gap > 0) begin
          h = src_q[k].pop_front();
          h.gap = h.gap - 4'd1;
          src_q[k].push_front(h);
        end
      end
      cyc++;
    end
    i_in_vld  = '0;
    i_in_last = '0;
    i_out_rdy = 1'b1;
    check({name, "_cycles"}, 32'(cyc), 32'(exp_cycles));
    exp_q.delete();
    for (int k = 0; k < N; k++) src_q[k].delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vecs[9];
    // From ptr=0 with the output always drained.
    vecs[0] = '{vld: 4'b0000, last: 4'b1111, exp_rdy: 4'b0000};
    vecs[1] = '{vld: 4'b0110, last: 4'b1111, exp_rdy: 4'b0010};
    vecs[2] = '{vld: 4'b0011, last: 4'b1111, exp_rdy: 4'b0001};
    vecs[3] = '{vld: 4'b1100, last: 4'b1111, exp_rdy: 4'b0100};
    vecs[4] = '{vld: 4'b0111, last: 4'b1111, exp_rdy: 4'b0001};
    vecs[5] = '{vld: 4'b0001, last: 4'b0000, exp_rdy: 4'b0001};
    vecs[6] = '{vld: 4'b1110, last: 4'b0000, exp_rdy: 4'b0001};
    vecs[7] = '{vld: 4'b0001, last: 4'b0001, exp_rdy: 4'b0001};
    vecs[8] = '{vld: 4'b1000, last: 4'b1111, exp_rdy: 4'b1000};

    rst       = 1'b1;
    i_in_vld  = 4'b1111;
    i_in_last = 4'b1111;
    i_in_w    = '0;
    i_out_rdy = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_rdy", 32'(o_in_rdy), 32'd0);
    check("reset_out_vld", 32'(o_out_vld), 32'd0);
    check("reset_out_w", 32'(o_out_w), 32'd0);
    check("reset_out_last", 32'(o_out_last), 32'd0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    i_in_vld = '0;

    for (int r = 0; r < 9; r++) begin
      i_in_vld  = vecs[r].vld;
      i_in_last = vecs[r].last;
      for (int k = 0; k < N; k++) i_in_w[k] = W'((r + 1) * 16 + k);
      for (int k = 0; k < N; k++) begin
        if (vecs[r].exp_rdy[k] && vecs[r].vld[k])
          exp_q.push_back('{w: W'((r + 1) * 16 + k), last: vecs[r].last[k]});
      end
      @(negedge clk);
      check($sformatf("arb_row%0d_rdy", r), 32'(o_in_rdy), 32'(vecs[r].exp_rdy));
      @(posedge clk);
      #1;
    end
    i_in_vld = '0;
    repeat (2) @(posedge clk);
    #1;
    check("table_drained", 32'(exp_q.size()), 32'd0);

    // Four single-beat packets: one per cycle, first output two cycles in.
    src(0, 8'h01, 1'b1, 0);
    src(1, 8'h02, 1'b1, 0);
    src(2, 8'h03, 1'b1, 0);
    src(3, 8'h04, 1'b1, 0);
    run_src("rr_all", 99, 0, 5);

    // Three-beat packet on channel 1 blocks channel 2 until its last beat.
    src(1, 8'h11, 1'b0, 0);
    src(1, 8'h12, 1'b0, 0);
    src(1, 8'h13, 1'b1, 0);
    src(2, 8'h21, 1'b1, 0);
    run_src("lock_ch1", 99, 0, 5);

    // ptr is 3 here: channel 3 is searched before wrapping to channel 0.
    src(2, 8'h2b, 1'b1, 0);
    src(3, 8'h3c, 1'b1, 1);
    src(0, 8'h0d, 1'b1, 1);
    run_src("wrap", 99, 0, 4);

    // Locked channel 0 goes idle for two cycles; channel 3 must wait.
    src(0, 8'h01, 1'b0, 0);
    src(0, 8'h02, 1'b0, 2);
    src(0, 8'h03, 1'b1, 0);
    src(3, 8'h31, 1'b1, 1);
    run_src("lock_gap", 99, 0, 7);

    // Downstream stall for five cycles with 0xA5 held on the output.
    src(0, 8'ha5, 1'b1, 0);
    src(1, 8'hb6, 1'b1, 0);
    src(2, 8'hc7, 1'b1, 0);
    src(3, 8'hd8, 1'b1, 0);
    run_src("stall", 1, 5, 10);

    // Reset in the middle of a channel 2 packet.
    i_out_rdy = 1'b1;
    i_in_vld  = 4'b0100;
    i_in_last = 4'b0000;
    i_in_w    = '0;
    i_in_w[2] = 8'h21;
    exp_q.push_back('{w: 8'h21, last: 1'b0});
    @(negedge clk);
    check("rst_mid_pkt_rdy", 32'(o_in_rdy), 32'b0100);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    i_in_w[2] = 8'h22;
    @(negedge clk);
    check("rst_asserted_rdy", 32'(o_in_rdy), 32'd0);
    check("rst_asserted_vld", 32'(o_out_vld), 32'd1);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    i_in_vld  = 4'b0110;
    i_in_last = 4'b0110;
    i_in_w[1] = 8'h31;
    i_in_w[2] = 8'h32;
    exp_q.push_back('{w: 8'h31, last: 1'b1});
    @(negedge clk);
    check("post_rst_vld", 32'(o_out_vld), 32'd0);
    check("post_rst_w", 32'(o_out_w), 32'd0);
    check("post_rst_rdy", 32'(o_in_rdy), 32'b0010);
    @(posedge clk);
    #1;
    i_in_vld  = 4'b0100;
    i_in_last = 4'b0100;
    exp_q.push_back('{w: 8'h32, last: 1'b1});
    @(negedge clk);
    check("post_rst_rdy2", 32'(o_in_rdy), 32'b0100);
    @(posedge clk);
    #1;
    i_in_vld = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_seq_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rr_pkt_arbiter.md
RR_PKT_ARBITER -- requirements
Module: rr_pkt_arbiter

Interface
REQ-001 SHALL have parameter N, default 4: number of requester channels, N >= 2.
REQ-002 SHALL have parameter W, default 32: beat data width, W >= 1.
REQ-003 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port i_in_vld, input, [N-1:0]: per-channel beat valid.
REQ-006 SHALL have port i_in_w, input, [N-1:0][W-1:0]: per-channel beat data.
REQ-007 SHALL have port i_in_last, input, [N-1:0]: per-channel end-of-packet marker.
REQ-008 SHALL have port o_in_rdy, output, [N-1:0]: per-channel accept; at most one bit set per cycle.
REQ-009 SHALL have port o_out_vld, output, 1 bit: registered output beat valid.
REQ-010 SHALL have port o_out_w, output, [W-1:0]: registered output beat data.
REQ-011 SHALL have port o_out_last, output, 1 bit: registered output end-of-packet marker.
REQ-012 SHALL have port i_out_rdy, input, 1 bit: downstream accept.

Function
REQ-013 A beat SHALL transfer on a channel when i_in_vld[k] and o_in_rdy[k] are both 1 in the same cycle; on the output when o_out_vld and i_out_rdy are both 1.
REQ-014 Output register load enable: ld = !o_out_vld || i_out_rdy; o_in_rdy SHALL be zero whenever ld is 0.
REQ-015 The state machine SHALL have two states: IDLE (no packet in progress) and LOCK (packet in progress on channel lk).
REQ-016 In IDLE, grant SHALL go to the first channel with i_in_vld set, searching ptr, ptr+1, ... modulo N; no valid channel means no grant.
REQ-017 In LOCK, grant SHALL be channel lk only, whether or not i_in_vld[lk] is set; other channels SHALL see o_in_rdy = 0.
REQ-018 o_in_rdy SHALL equal onehot(grant) AND ld, and SHALL not depend on the granted channel's i_in_vld.
REQ-019 Transition IDLE->LOCK SHALL occur on an accepted beat with last=0; lk latches the granted index.
REQ-020 Transition LOCK->IDLE SHALL occur on an accepted beat with last=1 on lk.
REQ-021 An accepted beat with last=1 SHALL set ptr = (granted index + 1) mod N; a single-beat packet accepted in IDLE stays in IDLE.
REQ-022 An accepted beat SHALL appear on o_out_* in the next cycle (latency 1); sustained throughput SHALL be 1 beat/cycle when i_out_rdy=1.
REQ-023 When ld=1 and no beat is accepted, o_out_vld SHALL clear; o_out_w and o_out_last SHALL hold.
REQ-024 While o_out_vld=1 and i_out_rdy=0, o_out_vld, o_out_w and o_out_last SHALL remain stable.
REQ-025 Data selection SHALL use the one-hot grant so that non-granted channel data never reaches o_out_w.

Reset
REQ-026 While rst=1 at a clock edge: state=IDLE, ptr=0, lk=0, o_out_vld=0, o_out_w=0, o_out_last=0.
REQ-027 While rst=1, o_in_rdy SHALL be all zeros.
REQ-028 Reset asserted mid-packet SHALL abandon the packet; after reset, arbitration restarts from channel 0.

Structure
REQ-029 The state enum (IDLE, LOCK) SHALL be defined in the shared common package; N and W stay module parameters.
REQ-030 Beat data selection SHALL instantiate the existing common one-hot AND-OR mux (parameters N, W) with grant as select; no other sub-module.
REQ-031 ptr and lk SHALL be $clog2(N) bits wide; wrap from N-1 to 0 SHALL be explicit for N not a power of two.

Verification (N=4, W=8)
REQ-032 After reset, all four channels present single-beat packets with i_out_rdy=1 -> outputs from channels 0,1,2,3 on consecutive cycles; first o_out_vld in cycle 2 after the first request.
REQ-033 Channel 1 sends 3 beats (0x11,0x12,0x13 with last on 0x13) while channel 2 requests -> output 0x11,0x12,0x13, then channel 2; o_in_rdy[2] stays 0 throughout.
REQ-034 Locked channel 0 deasserts i_in_vld for 2 cycles mid-packet while channel 3 requests -> no beat from channel 3 until channel 0's last beat is accepted.
REQ-035 i_out_rdy held at 0 for 5 cycles with o_out_vld=1 and data 0xA5 -> o_out_w stays 0xA5, o_in_rdy all zero; one beat accepted per cycle once i_out_rdy returns to 1.
REQ-036 Set ptr=3 with only channel 3 and channel 0 requesting single beats -> channel 3, then channel 0 (wrap-around).
REQ-037 rst pulsed mid-packet on channel 2 -> o_out_vld=0 the next cycle; a subsequent channel 1 and channel 2 request resolves to channel 1 first.
